sram_ctrl: RTL and testbench
============================

# sram_ctrl

Single-port SRAM controller sitting directly downstream of the two-port RAM arbiter in the SoC memory subsystem. It accepts the arbiter's RAM-side request bundle (enable, address, write-enable, byte enables, write data), drives a synchronous single-port SRAM macro, and returns the completion/read-data handshake (`rvalid_o`, `rdata_o`) the arbiter waits on. It inserts a parameterised number of wait states to model slower macros.

## Interface
- `ADDR_WIDTH`, 32: byte address width from the arbiter.
- `DATA_WIDTH`, 32: data width. Must be a multiple of 8.
- `RAM_ADDR_WIDTH`, 12: word address width of the macro.
- `WAIT_CYCLES`, 0: extra cycles between macro access and response. Legal range 0..15.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en_i` in 1: request valid from arbiter.
- `addr_i` in ADDR_WIDTH: byte address.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in DATA_WIDTH/8: byte enables.
- `wdata_i` in DATA_WIDTH: write data.
- `rdata_o` out DATA_WIDTH: read data, meaningful only with `rvalid_o`.
- `rvalid_o` out 1: one-cycle completion pulse, for reads and writes.
- `busy_o` out 1: a request is in flight.
- `sram_cs_o` out 1: macro chip select.
- `sram_we_o` out 1: macro write enable.
- `sram_addr_o` out RAM_ADDR_WIDTH: macro word address, `addr_i[RAM_ADDR_WIDTH+1:2]`.
- `sram_wdata_o` out DATA_WIDTH: macro write data, `wdata_i` passed through.
- `sram_bmask_o` out DATA_WIDTH: bit write mask; each `be_i` bit is replicated ×8.
- `sram_rdata_i` in DATA_WIDTH: macro read data, valid the cycle after a read access.

## Operation
- States: IDLE, BUSY. A 4-bit down-counter `cnt` is used in BUSY.
- Accept condition: `en_i & ~rst & (state==IDLE | rvalid_o)`. A new request may be accepted in the same cycle as the previous response, which gives back-to-back operation.
- Macro drive:
  - `sram_cs_o = accept`.
  - `sram_we_o = accept & we_i`.
  - Address, wdata and bmask are combinational from the inputs.
  - No macro access occurs in any other cycle.
- On accept:
  - Go to BUSY.
  - Load `cnt = WAIT_CYCLES`.
  - Latch `we_q = we_i`.
- First BUSY cycle: capture `sram_rdata_i` into `rdata_q` if `we_q = 0`.
- In BUSY:
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, assert `rvalid_o`. Then go to BUSY if another request is accepted that cycle, otherwise go to IDLE.
- `rdata_o` during a read response:
  - `sram_rdata_i` when WAIT_CYCLES = 0.
  - `rdata_q` otherwise.
- `rdata_o` during a write response: 0.
- `rdata_o` outside a response: 0.
- While BUSY and not responding, `en_i` and the request fields are ignored. The arbiter holds them stable.
- `be_i = 0` on a write: no bytes are modified, and the completion is still returned.
- Address bits `[1:0]` and bits above `RAM_ADDR_WIDTH+1` are ignored; the address wraps modulo the macro size.
- `busy_o = (state == BUSY)`.

## Timing
- Reset values: `rvalid_o`=0, `rdata_o`=0, `busy_o`=0, `sram_cs_o`=0, `sram_we_o`=0. State is IDLE, and `cnt`, `we_q`, `rdata_q` are 0. Macro address, wdata and bmask follow the inputs.
- Latency: for a request accepted in cycle T, `rvalid_o` is high in cycle T+1+WAIT_CYCLES.
- Throughput: one access per 1+WAIT_CYCLES cycles. With WAIT_CYCLES=0, one access per cycle.
- Reset asserted mid-operation: the in-flight response is dropped and no `rvalid_o` is produced. `sram_cs_o` is forced to 0 during any `rst` cycle.
- Simultaneous response and new request: the response is delivered and the new request is accepted with the macro accessed in the same cycle. The new read data must not corrupt the response being delivered.

## Configuration
- `SRAM_CTRL_RDATA_REG_EN`
  - Defined: the response is always returned from a register stage. `rvalid_o` appears in cycle T+2+WAIT_CYCLES, and `rdata_o` is driven only from flops. Back-to-back accept happens in the response cycle as before, so throughput is one access per 2+WAIT_CYCLES cycles.
  - Undefined: timing is as described in Timing above.

## Test plan
- Reset, WAIT_CYCLES=0: hold `rst` 3 cycles with `en_i`=1 → `sram_cs_o`, `rvalid_o` and `rdata_o` stay 0. After release, IDLE with `busy_o`=0.
- Write then read, WAIT_CYCLES=0:
  - Write `addr_i`=0x104, `wdata_i`=0xDEADBEEF, `be_i`=0xF → `sram_addr_o`=0x041, `sram_bmask_o`=0xFFFFFFFF, `rvalid_o` in T+1 with `rdata_o`=0.
  - Then read 0x104 → `rdata_o`=0xDEADBEEF in T+1.
- Partial write: over 0xDEADBEEF, write `be_i`=0x3, `wdata_i`=0x00001234 → `sram_bmask_o`=0x0000FFFF. A subsequent read returns 0xDEAD1234.
- Wait states, WAIT_CYCLES=3: read accepted at T → `rvalid_o` only at T+4, `busy_o` high T+1..T+4. Changing `en_i`/`addr_i` during T+1..T+3 causes no extra `sram_cs_o`.
- Back-to-back reads, WAIT_CYCLES=0:
  - Requests to 0x0, 0x4 and 0x8 on consecutive cycles → three consecutive `rvalid_o` with the correct data in order.
  - WAIT_CYCLES=2 with `en_i` held → accepts on cycles T, T+3, T+6.
- Mid-operation reset, WAIT_CYCLES=3: `rst` pulsed at T+2 → no `rvalid_o` for that request, IDLE at T+3. A new read at T+4 returns its response at T+8.

Source files
------------

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller with WAIT_CYCLES extra cycles before each response.
// Define SRAM_CTRL_RDATA_REG_EN to return every response from a register stage.
module sram_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int RAM_ADDR_WIDTH = 12,
   parameter int WAIT_CYCLES    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic                      we_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      rvalid_o,
   output logic                      busy_o,
   output logic                      sram_cs_o,
   output logic                      sram_we_o,
   output logic [RAM_ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0]     sram_wdata_o,
   output logic [DATA_WIDTH-1:0]     sram_bmask_o,
   input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);

   localparam int         BE_WIDTH = DATA_WIDTH / 8;
   localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nxt;
   logic                  r_we_q;
   logic [DATA_WIDTH-1:0] r_rdata_q;
   logic                  w_resp;
   logic                  w_capture;
   logic                  w_accept;
   logic [DATA_WIDTH-1:0] w_resp_data;
   logic [DATA_WIDTH-1:0] w_bmask;
   logic                  w_unused;

   // Internal response point: last BUSY cycle; a reset cycle drops it.
   assign w_resp    = (r_state == ST_BUSY) && (r_cnt == 4'd0) && !rst;
   // The macro's read data is only valid in the first BUSY cycle, where cnt is still at its load value.
   assign w_capture = (r_state == ST_BUSY) && (r_cnt == WAIT_LD) && !r_we_q;
   assign w_accept  = en_i && !rst && ((r_state == ST_IDLE) || rvalid_o);

   assign sram_cs_o    = w_accept;
   assign sram_we_o    = w_accept && we_i;
   assign sram_addr_o  = addr_i[RAM_ADDR_WIDTH+1:2];
   assign sram_wdata_o = wdata_i;
   assign sram_bmask_o = w_bmask;
   assign busy_o       = (r_state == ST_BUSY);
   assign w_unused     = ^{addr_i[1:0], addr_i[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]};

   // Byte enables expanded to a per-bit write mask
   always_comb begin
      w_bmask = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         w_bmask[i*8 +: 8] = {8{be_i[i]}};
      end
   end

   // Response data: live macro output without wait states, captured copy otherwise
   always_comb begin
      w_resp_data = '0;
      if (w_resp && !r_we_q) begin
         if (WAIT_CYCLES == 0) begin
            w_resp_data = sram_rdata_i;
         end else begin
            w_resp_data = r_rdata_q;
         end
      end else begin
         w_resp_data = '0;
      end
   end

   // Next-state and wait counter
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = WAIT_LD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (w_accept) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = WAIT_LD;
            end else if (r_cnt != 4'd0) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = r_cnt - 4'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State, counter, request type and captured read data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_we_q    <= 1'b0;
         r_rdata_q <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we_q <= we_i;
         end
         if (w_capture) begin
            r_rdata_q <= sram_rdata_i;
         end
      end
   end

`ifdef SRAM_CTRL_RDATA_REG_EN
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;

   // Output register stage: response leaves one cycle after the internal response point
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_resp;
         r_rdata  <= w_resp_data;
      end
   end

   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;
`else
   assign rvalid_o = w_resp;
   assign rdata_o  = w_resp_data;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 0, 2, 3), each with its own macro model;
// a scoreboard queue holds the expected response data and arrival cycle per request.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_RDATA_REG_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   typedef struct {
      int          dut;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        en_d;
   int          sel;
   logic        we_d;
   logic [31:0] addr_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;

   logic        cs_a     [3];
   logic        swe_a    [3];
   logic        rvalid_a [3];
   logic        busy_a   [3];
   logic [11:0] saddr_a  [3];
   logic [31:0] swd_a    [3];
   logic [31:0] bm_a     [3];
   logic [31:0] rdata_a  [3];

   logic [31:0] ref_mem [3][4096];
   exp_t        sb[$];
   int          cyc;
   int          pass_cnt;
   int          total_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
      logic [31:0] mem [4096];
      logic [31:0] rd;

      initial begin
         for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      end

      // Synchronous macro model: read data appears the cycle after the access
      always @(posedge clk) begin
         if (cs_a[g]) begin
            if (swe_a[g]) mem[saddr_a[g]] <= (mem[saddr_a[g]] & ~bm_a[g]) | (swd_a[g] & bm_a[g]);
            else          rd <= mem[saddr_a[g]];
         end
      end

      sram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_ADDR_WIDTH(12), .WAIT_CYCLES(W)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .en_i         (en_d && (sel == g)),
         .addr_i       (addr_d),
         .we_i         (we_d),
         .be_i         (be_d),
         .wdata_i      (wdata_d),
         .rdata_o      (rdata_a[g]),
         .rvalid_o     (rvalid_a[g]),
         .busy_o       (busy_a[g]),
         .sram_cs_o    (cs_a[g]),
         .sram_we_o    (swe_a[g]),
         .sram_addr_o  (saddr_a[g]),
         .sram_wdata_o (swd_a[g]),
         .sram_bmask_o (bm_a[g]),
         .sram_rdata_i (rd)
      );
   end

   function automatic int waits(input int g);
      case (g)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   task automatic mid();
      @(negedge clk);
   endtask

   // Scoreboard pass for the current cycle, then advance to the next cycle
   task automatic step();
      exp_t e;
      if (sb.size() != 0 && sb[0].cyc < cyc) begin
         total_cnt++;
         $display("FAIL missing_rvalid: dut %0d got no response, required one at cycle %0d", sb[0].dut, sb[0].cyc);
         void'(sb.pop_front());
      end
      for (int g = 0; g < 3; g++) begin
         total_cnt++;
         if (rvalid_a[g]) begin
            if (sb.size() == 0 || sb[0].dut != g) begin
               $display("FAIL unexpected_rvalid: dut %0d got rvalid=1 at cycle %0d, required 0", g, cyc);
            end else begin
               e = sb.pop_front();
               if (rdata_a[g] !== e.data || cyc != e.cyc)
                  $display("FAIL response: dut %0d got data %h at cycle %0d, required %h at cycle %0d",
                           g, rdata_a[g], cyc, e.data, e.cyc);
               else pass_cnt++;
            end
         end else begin
            if (rdata_a[g] !== 32'h0)
               $display("FAIL idle_rdata: dut %0d got %h, required 00000000", g, rdata_a[g]);
            else pass_cnt++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drive a request this cycle; optionally push its expected response
   task automatic issue(input int g, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input bit push);
      exp_t        e;
      logic [11:0] w;
      logic [31:0] m;
      sel = g; en_d = 1'b1; we_d = we; addr_d = addr; be_d = be; wdata_d = wd;
      w = addr[13:2];
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
      if (we) begin
         ref_mem[g][w] = (ref_mem[g][w] & ~m) | (wd & m);
         e.data = 32'h0;
      end else begin
         e.data = ref_mem[g][w];
      end
      e.dut = g;
      e.cyc = cyc + 1 + waits(g) + EXTRA;
      if (push) sb.push_back(e);
   endtask

   task automatic drain();
      en_d = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         mid();
         step();
      end
      total_cnt++;
      if (sb.size() != 0) $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      else pass_cnt++;
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 0; en_d = 1'b1; we_d = 1'b0; addr_d = 32'h104; be_d = 4'hF; wdata_d = 32'h0;
      for (int i = 0; i < 3; i++) begin
         mid();
         total_cnt++;
         if (cs_a[0] !== 1'b0 || rvalid_a[0] !== 1'b0)
            $display("FAIL reset_outputs: got cs=%b rvalid=%b, required 0 0", cs_a[0], rvalid_a[0]);
         else pass_cnt++;
         step();
      end
      rst = 1'b0; en_d = 1'b0;
      mid();
      for (int g = 0; g < 3; g++) begin
         total_cnt++;
         if (busy_a[g] !== 1'b0) $display("FAIL reset_busy: dut %0d got %b, required 0", g, busy_a[g]);
         else pass_cnt++;
      end
      step();
   endtask

   task automatic test_write_read();
      issue(0, 1'b1, 32'h104, 4'hF, 32'hDEADBEEF, 1'b1);
      mid();
      total_cnt++;
      if (cs_a[0] !== 1'b1 || swe_a[0] !== 1'b1 || saddr_a[0] !== 12'h041 ||
          bm_a[0] !== 32'hFFFFFFFF || swd_a[0] !== 32'hDEADBEEF)
         $display("FAIL write_drive: got cs=%b we=%b addr=%h bmask=%h wdata=%h, required 1 1 041 ffffffff deadbeef",
                  cs_a[0], swe_a[0], saddr_a[0], bm_a[0], swd_a[0]);
      else pass_cnt++;
      step();
      drain();
      issue(0, 1'b0, 32'h104, 4'hF, 32'h0, 1'b1);
      mid();
      total_cnt++;
      if (cs_a[0] !== 1'b1 || swe_a[0] !== 1'b0)
         $display("FAIL read_drive: got cs=%b we=%b, required 1 0", cs_a[0], swe_a[0]);
      else pass_cnt++;
      step();
      drain();
   endtask

   task automatic test_partial();
      issue(0, 1'b1, 32'h104, 4'h3, 32'h00001234, 1'b1);
      mid();
      total_cnt++;
      if (bm_a[0] !== 32'h0000FFFF) $display("FAIL partial_bmask: got %h, required 0000ffff", bm_a[0]);
      else pass_cnt++;
      step();
      drain();
      issue(0, 1'b1, 32'h104, 4'h0, 32'hFFFFFFFF, 1'b1);
      mid();
      total_cnt++;
      if (bm_a[0] !== 32'h0 || cs_a[0] !== 1'b1)
         $display("FAIL zero_be: got bmask=%h cs=%b, required 00000000 1", bm_a[0], cs_a[0]);
      else pass_cnt++;
      step();
      drain();
      // High and low address bits are ignored: 0x4106 aliases word 0x041
      issue(0, 1'b0, 32'h00004106, 4'hF, 32'h0, 1'b1);
      mid();
      total_cnt++;
      if (saddr_a[0] !== 12'h041) $display("FAIL addr_wrap: got %h, required 041", saddr_a[0]);
      else pass_cnt++;
      step();
      drain();
   endtask

   task automatic test_wait_states();
      issue(2, 1'b1, 32'h200, 4'hF, 32'hA5A55A5A, 1'b1);
      mid(); step();
      drain();
      issue(2, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1);
      mid(); step();
      for (int k = 1; k <= 3; k++) begin
         en_d = 1'b1; we_d = 1'b1; addr_d = 32'h300 + 32'(k * 4); wdata_d = 32'hFFFFFFFF;
         mid();
         total_cnt++;
         if (cs_a[2] !== 1'b0 || busy_a[2] !== 1'b1)
            $display("FAIL wait_ignore: T+%0d got cs=%b busy=%b, required 0 1", k, cs_a[2], busy_a[2]);
         else pass_cnt++;
         step();
      end
      en_d = 1'b0;
      mid();
      total_cnt++;
      if (busy_a[2] !== 1'b1) $display("FAIL wait_busy_t4: got %b, required 1", busy_a[2]);
      else pass_cnt++;
      step();
      mid();
      total_cnt++;
      if (busy_a[2] !== 1'b0) $display("FAIL wait_busy_t5: got %b, required 0", busy_a[2]);
      else pass_cnt++;
      step();
      drain();
   endtask

   // Three writes then three reads to 0x0/0x4/0x8, each held until its slot is over
   task automatic test_back_to_back(input int g);
      int period;
      period = 1 + waits(g) + EXTRA;
      for (int i = 0; i < 6; i++) begin
         for (int p = 0; p < period; p++) begin
            if (p == 0)
               issue(g, (i < 3), 32'((i % 3) * 4), 4'hF, (32'h11111111 * 32'(i + 1)) ^ 32'(g), 1'b1);
            mid();
            total_cnt++;
            if (cs_a[g] !== (p == 0))
               $display("FAIL b2b_accept: dut %0d req %0d slot %0d got cs=%b, required %0b", g, i, p, cs_a[g], (p == 0));
            else pass_cnt++;
            step();
         end
      end
      drain();
   endtask

   task automatic test_mid_reset();
      issue(2, 1'b0, 32'h200, 4'hF, 32'h0, 1'b0);
      mid(); step();
      en_d = 1'b0;
      mid(); step();
      rst = 1'b1; en_d = 1'b1;
      mid();
      total_cnt++;
      if (cs_a[2] !== 1'b0) $display("FAIL rst_cs: got %b, required 0", cs_a[2]);
      else pass_cnt++;
      step();
      rst = 1'b0; en_d = 1'b0;
      mid();
      total_cnt++;
      if (busy_a[2] !== 1'b0) $display("FAIL rst_idle: got busy=%b, required 0", busy_a[2]);
      else pass_cnt++;
      step();
      issue(2, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1);
      mid(); step();
      drain();
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0; cyc = 0;
      rst = 1'b1; en_d = 1'b0; sel = 0; we_d = 1'b0; addr_d = 32'h0; be_d = 4'h0; wdata_d = 32'h0;
      for (int g = 0; g < 3; g++)
         for (int i = 0; i < 4096; i++) ref_mem[g][i] = 32'h0;
      @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_partial();
      test_wait_states();
      test_back_to_back(0);
      test_back_to_back(1);
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
